// File: rtl/eth_packet_tx.sv
// ============================================================================
// Module   : eth_packet_tx
// Purpose  : Byte-wide Ethernet frame transmitter (preamble..FCS, then IFG).
//            Optional CRC-32 FCS generation enabled by macro FCS_GEN_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_packet_tx #(
    parameter int IFG_CYCLES  = 12,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] dst_addr,
    input  logic [47:0] src_addr,
    input  logic [15:0] type_length,
    input  logic [10:0] payload_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  data,
    output logic        control,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [3:0]  tx_count
);

    localparam logic [10:0] C_MIN_P = 11'(MIN_PAYLOAD);
    localparam logic [10:0] C_MAX_P = 11'(MAX_PAYLOAD);
    localparam logic [10:0] C_IFG   = 11'(IFG_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    // state_q/cnt_q name the byte that the next clock edge will emit
    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        control_q, control_d;
    logic        busy_q, busy_d;
    logic        pl_ready_q, pl_ready_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic [3:0]  tx_count_q, tx_count_d;
    logic [7:0]  fcs_byte;

`ifdef FCS_GEN_EN
    logic [31:0] crc_q, crc_d;
    logic        crc_upd;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dst_d        = dst_q;
        src_d        = src_q;
        type_d       = type_q;
        len_d        = len_q;
        data_d       = 8'h00;
        control_d    = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        tx_count_d   = tx_count_q;
`ifdef FCS_GEN_EN
        crc_d   = crc_q;
        crc_upd = (state_q == S_DST) || (state_q == S_SRC) || (state_q == S_TYPE) ||
                  (state_q == S_PAD) || ((state_q == S_PAYLOAD) && pl_valid);
        case (cnt_q[1:0])
            2'd0:    fcs_byte = ~crc_q[7:0];
            2'd1:    fcs_byte = ~crc_q[15:8];
            2'd2:    fcs_byte = ~crc_q[23:16];
            default: fcs_byte = ~crc_q[31:24];
        endcase
`else
        fcs_byte = 8'h00;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                dst_d     = dst_addr;
                src_d     = src_addr;
                type_d    = type_length;
                len_d     = (payload_len > C_MAX_P) ? C_MAX_P : payload_len;
                data_d    = 8'h55;
                control_d = 1'b1;
                busy_d    = 1'b1;
                state_d   = S_PRE;
                cnt_d     = 11'd1;
`ifdef FCS_GEN_EN
                crc_d     = 32'hFFFFFFFF;
`endif
            end
            S_PRE: begin
                data_d    = 8'h55;
                control_d = 1'b1;
                if (cnt_q == 11'd6) state_d = S_SFD;
                else                cnt_d   = cnt_q + 11'd1;
            end
            S_SFD: begin
                data_d    = 8'hD5;
                control_d = 1'b1;
                state_d   = S_DST;
                cnt_d     = 11'd0;
            end
            S_DST: begin
                data_d    = dst_q[47:40];
                control_d = 1'b1;
                dst_d     = {dst_q[39:0], 8'h00};
                if (cnt_q == 11'd5) begin state_d = S_SRC; cnt_d = 11'd0; end
                else                cnt_d = cnt_q + 11'd1;
            end
            S_SRC: begin
                data_d    = src_q[47:40];
                control_d = 1'b1;
                src_d     = {src_q[39:0], 8'h00};
                if (cnt_q == 11'd5) begin state_d = S_TYPE; cnt_d = 11'd0; end
                else                cnt_d = cnt_q + 11'd1;
            end
            S_TYPE: begin
                data_d    = type_q[15:8];
                control_d = 1'b1;
                type_d    = {type_q[7:0], 8'h00};
                if (cnt_q == 11'd1) begin
                    cnt_d = 11'd0;
                    if (len_q != 11'd0)        state_d = S_PAYLOAD;
                    else if (C_MIN_P != 11'd0) state_d = S_PAD;
                    else                       state_d = S_FCS;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_PAYLOAD: if (pl_valid) begin
                data_d    = pl_data;
                control_d = 1'b1;
                if (cnt_q == len_q - 11'd1) begin
                    if (len_q < C_MIN_P) begin state_d = S_PAD; cnt_d = cnt_q + 11'd1; end
                    else                 begin state_d = S_FCS; cnt_d = 11'd0; end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end else begin
                // Starved mid-payload: drop the frame and fall straight into the gap
                underrun_d = 1'b1;
                state_d    = S_IFG;
                cnt_d      = 11'd0;
            end
            S_PAD: begin
                control_d = 1'b1;
                if (cnt_q == C_MIN_P - 11'd1) begin state_d = S_FCS; cnt_d = 11'd0; end
                else                          cnt_d = cnt_q + 11'd1;
            end
            S_FCS: begin
                data_d    = fcs_byte;
                control_d = 1'b1;
                if (cnt_q == 11'd3) begin
                    frame_done_d = 1'b1;
                    tx_count_d   = tx_count_q + 4'd1;
                    state_d      = S_IFG;
                    cnt_d        = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_IFG: begin
                if (cnt_q == C_IFG - 11'd1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pl_ready_d = (state_d == S_PAYLOAD);
`ifdef FCS_GEN_EN
        if (crc_upd) crc_d = crc32_byte(crc_q, data_d);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dst_q        <= '0;
            src_q        <= '0;
            type_q       <= '0;
            len_q        <= '0;
            data_q       <= 8'h00;
            control_q    <= 1'b0;
            busy_q       <= 1'b0;
            pl_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            tx_count_q   <= 4'd0;
`ifdef FCS_GEN_EN
            crc_q        <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            type_q       <= type_d;
            len_q        <= len_d;
            data_q       <= data_d;
            control_q    <= control_d;
            busy_q       <= busy_d;
            pl_ready_q   <= pl_ready_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            tx_count_q   <= tx_count_d;
`ifdef FCS_GEN_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign pl_ready   = pl_ready_q;
    assign data       = data_q;
    assign control    = control_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign tx_count   = tx_count_q;

endmodule

`default_nettype wire
